// File: rtl/fifo_port_arbiter.sv
// Two-requester (producer write / consumer read) arbiter in front of a single FIFO port.
// Define FIFOARB_FIXED_PRIO_EN to give writes fixed priority instead of round-robin.
module fifo_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ack,
  output logic                  fifo_we,
  output logic                  fifo_re,
  output logic [DATA_WIDTH-1:0] fifo_din,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_busy,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  output logic                  arb_error
);

  localparam logic [7:0] TimeoutLast = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e     state_q;
  logic       rd_sel_q;    // the transaction in flight is a read
  logic [7:0] wait_cnt_q;
  logic       wr_elig;
  logic       rd_elig;
  logic       grant_wr;
  logic       grant_rd;

`ifndef FIFOARB_FIXED_PRIO_EN
  logic       rr_rd_q;     // 1: read wins the next tie
`endif

  always_comb begin
    wr_elig = wr_req && !fifo_full && !fifo_busy;
    rd_elig = rd_req && !fifo_empty && !fifo_busy;
`ifdef FIFOARB_FIXED_PRIO_EN
    grant_wr = wr_elig;
`else
    grant_wr = wr_elig && (!rd_elig || !rr_rd_q);
`endif
    grant_rd = rd_elig && !grant_wr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rd_sel_q   <= 1'b0;
      wait_cnt_q <= '0;
`ifndef FIFOARB_FIXED_PRIO_EN
      rr_rd_q    <= 1'b0;
`endif
      fifo_we    <= 1'b0;
      fifo_re    <= 1'b0;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      fifo_din   <= '0;
      rd_data    <= '0;
      arb_error  <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses.
      fifo_we <= 1'b0;
      fifo_re <= 1'b0;
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_wr || grant_rd) begin
            rd_sel_q <= grant_rd;
            fifo_we  <= grant_wr;
            fifo_re  <= grant_rd;
            if (grant_wr) fifo_din <= wr_data;
`ifndef FIFOARB_FIXED_PRIO_EN
            if (wr_elig && rd_elig) rr_rd_q <= grant_wr;
`endif
            state_q <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (!fifo_busy || (wait_cnt_q == TimeoutLast)) begin
            // A stuck FIFO still gets an ack so the requester is released.
            if (fifo_busy) arb_error <= 1'b1;
            if (rd_sel_q) rd_data <= fifo_dout;
            wr_ack  <= !rd_sel_q;
            rd_ack  <= rd_sel_q;
            state_q <= StAck;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StAck: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter: vector table plus multi-cycle corner sequences.
module tb_fifo_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req, rd_req;
  logic [7:0] wr_data, fifo_dout;
  logic       fifo_busy, fifo_empty, fifo_full;

  logic       wr_ack, rd_ack, fifo_we, fifo_re, arb_error;
  logic [7:0] rd_data, fifo_din;
  logic       wr_ack_t, rd_ack_t, fifo_we_t, fifo_re_t, arb_error_t;
  logic [7:0] rd_data_t, fifo_din_t;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_port_arbiter #(.DATA_WIDTH(8), .BUSY_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack), .fifo_we(fifo_we),
    .fifo_re(fifo_re), .fifo_din(fifo_din), .fifo_dout(fifo_dout), .fifo_busy(fifo_busy),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .arb_error(arb_error)
  );

  fifo_port_arbiter #(.DATA_WIDTH(8), .BUSY_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack_t),
    .rd_req(rd_req), .rd_data(rd_data_t), .rd_ack(rd_ack_t), .fifo_we(fifo_we_t),
    .fifo_re(fifo_re_t), .fifo_din(fifo_din_t), .fifo_dout(fifo_dout),
    .fifo_busy(fifo_busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .arb_error(arb_error_t)
  );

  logic [20:0] act;
  assign act = {fifo_we, fifo_re, wr_ack, rd_ack, arb_error, fifo_din, rd_data};

  typedef struct {
    logic        wr;
    logic [7:0]  wd;
    logic        rd;
    logic        busy;
    logic        empty;
    logic        full;
    logic [7:0]  dout;
    logic [20:0] exp;
  } vec_t;

  function automatic logic [20:0] ov(input logic we, input logic re, input logic wa,
                                     input logic ra, input logic er, input logic [7:0] din,
                                     input logic [7:0] rdd);
    return {we, re, wa, ra, er, din, rdd};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd,
                              input logic busy, input logic empty, input logic full,
                              input logic [7:0] dout, input logic [20:0] exp);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.busy = busy;
    v.empty = empty; v.full = full; v.dout = dout; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00; fifo_dout = 8'h00;
    fifo_busy = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  vec_t vt[19];
  logic gr[4];
  logic exp_gr[4];
  int   ng;
  int   excl_viol;

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    check("reset_async_outputs", 32'(act), 32'd0);
    check("reset_async_to", 32'({fifo_we_t, wr_ack_t, arb_error_t}), 32'd0);
    repeat (2) tick();
    check("reset_held_outputs", 32'(act), 32'd0);
    reset = 1'b1;
    tick();

    // Each vector: inputs applied before an edge, outputs checked just after it.
    vt[0]  = mk(1, 8'hA5, 0, 0, 1, 0, 8'h00, ov(1, 0, 0, 0, 0, 8'hA5, 8'h00));
    vt[1]  = mk(1, 8'hA5, 0, 0, 1, 0, 8'h00, ov(0, 0, 0, 0, 0, 8'hA5, 8'h00));
    vt[2]  = mk(1, 8'hA5, 0, 0, 1, 0, 8'h00, ov(0, 0, 1, 0, 0, 8'hA5, 8'h00));
    vt[3]  = mk(0, 8'hA5, 0, 0, 1, 0, 8'h00, ov(0, 0, 0, 0, 0, 8'hA5, 8'h00));
    vt[4]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h3C, ov(0, 1, 0, 0, 0, 8'hA5, 8'h00));
    vt[5]  = mk(0, 8'h00, 1, 1, 0, 0, 8'h3C, ov(0, 0, 0, 0, 0, 8'hA5, 8'h00));
    vt[6]  = mk(0, 8'h00, 1, 1, 0, 0, 8'h3C, ov(0, 0, 0, 0, 0, 8'hA5, 8'h00));
    vt[7]  = mk(0, 8'h00, 1, 1, 0, 0, 8'h3C, ov(0, 0, 0, 0, 0, 8'hA5, 8'h00));
    vt[8]  = mk(0, 8'h00, 1, 1, 0, 0, 8'h3C, ov(0, 0, 0, 0, 0, 8'hA5, 8'h00));
    vt[9]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h3C, ov(0, 0, 0, 1, 0, 8'hA5, 8'h3C));
    vt[10] = mk(0, 8'h00, 0, 0, 0, 0, 8'h3C, ov(0, 0, 0, 0, 0, 8'hA5, 8'h3C));
    vt[11] = mk(1, 8'h77, 1, 0, 0, 1, 8'h5A, ov(0, 1, 0, 0, 0, 8'hA5, 8'h3C));
    vt[12] = mk(1, 8'h77, 1, 0, 0, 1, 8'h5A, ov(0, 0, 0, 0, 0, 8'hA5, 8'h3C));
    vt[13] = mk(1, 8'h77, 1, 0, 0, 1, 8'h5A, ov(0, 0, 0, 1, 0, 8'hA5, 8'h5A));
    vt[14] = mk(1, 8'h77, 0, 0, 0, 0, 8'h5A, ov(0, 0, 0, 0, 0, 8'hA5, 8'h5A));
    vt[15] = mk(1, 8'h77, 0, 0, 0, 0, 8'h5A, ov(1, 0, 0, 0, 0, 8'h77, 8'h5A));
    vt[16] = mk(1, 8'h77, 0, 0, 0, 0, 8'h5A, ov(0, 0, 0, 0, 0, 8'h77, 8'h5A));
    vt[17] = mk(1, 8'h77, 0, 0, 0, 0, 8'h5A, ov(0, 0, 1, 0, 0, 8'h77, 8'h5A));
    vt[18] = mk(0, 8'h77, 0, 0, 0, 0, 8'h5A, ov(0, 0, 0, 0, 0, 8'h77, 8'h5A));

    for (int i = 0; i < 19; i++) begin
      wr_req = vt[i].wr; wr_data = vt[i].wd; rd_req = vt[i].rd;
      fifo_busy = vt[i].busy; fifo_empty = vt[i].empty; fifo_full = vt[i].full;
      fifo_dout = vt[i].dout;
      tick();
      check($sformatf("vec%0d", i), 32'(act), 32'(vt[i].exp));
    end

    // Both requesters held: grant order from reset.
    do_reset();
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h11; fifo_dout = 8'h22;
    fifo_empty = 1'b0; fifo_full = 1'b0;
    ng = 0;
    excl_viol = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      if ($countones({fifo_we, fifo_re, wr_ack, rd_ack}) > 1) excl_viol++;
      if (fifo_we || fifo_re) begin
        gr[ng] = fifo_re;
        ng++;
      end
    end
    check("both_grant_count", 32'(ng), 32'd4);
    check("strobe_exclusive", 32'(excl_viol), 32'd0);
`ifdef FIFOARB_FIXED_PRIO_EN
    exp_gr = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_gr = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check($sformatf("both_grant%0d_is_read", i), 32'(gr[i]), 32'(exp_gr[i]));
    end
    idle_inputs();
    repeat (5) tick();

    // Busy stuck high in WAIT on the BUSY_TIMEOUT=4 instance.
    do_reset();
    wr_req = 1'b1; wr_data = 8'hC3;
    tick();
    check("to_issue_we", 32'({fifo_we_t, fifo_din_t}), {23'd0, 1'b1, 8'hC3});
    fifo_busy = 1'b1;
    repeat (4) tick();
    check("to_before_limit", 32'({arb_error_t, wr_ack_t}), 32'd0);
    tick();
    check("to_limit_err_ack", 32'({arb_error_t, wr_ack_t}), 32'd3);
    wr_req = 1'b0;
    repeat (3) tick();
    check("to_err_sticky", 32'({arb_error_t, wr_ack_t}), 32'd2);
    reset = 1'b0;
    #1;
    check("to_err_cleared", 32'(arb_error_t), 32'd0);
    reset = 1'b1;
    idle_inputs();
    tick();

    // Reset asserted while waiting on a busy FIFO.
    do_reset();
    wr_req = 1'b1; wr_data = 8'h96;
    tick();
    check("rw_issue", 32'(act), 32'(ov(1, 0, 0, 0, 0, 8'h96, 8'h00)));
    fifo_busy = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    check("rw_async_clear", 32'(act), 32'd0);
    fifo_busy = 1'b0;
    tick();
    check("rw_no_ack_in_reset", 32'(act), 32'd0);
    #2 reset = 1'b1;
    tick();
    check("rw_regrant", 32'(act), 32'(ov(1, 0, 0, 0, 0, 8'h96, 8'h00)));
    repeat (2) tick();
    check("rw_ack", 32'(act), 32'(ov(0, 0, 1, 0, 0, 8'h96, 8'h00)));
    wr_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_port_arbiter.md
FIFO_PORT_ARBITER -- requirements
Module: fifo_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall set the FIFO data width.
REQ-002 Parameter BUSY_TIMEOUT, default 255, shall set the maximum WAIT cycles before the timeout rule applies (range 1..255).
REQ-003 clk  input  1  shall be the single clock; all logic is rising-edge.
REQ-004 reset  input  1  shall be the asynchronous, active-low reset.
REQ-005 wr_req  input  1  shall be the producer write request, held until wr_ack.
REQ-006 wr_data  input  DATA_WIDTH  shall be the producer byte, stable while wr_req=1.
REQ-007 wr_ack  output  1  shall be a one-cycle pulse meaning the write completed.
REQ-008 rd_req  input  1  shall be the consumer read request, held until rd_ack.
REQ-009 rd_data  output  DATA_WIDTH  shall be the registered read byte, valid from rd_ack until the next read.
REQ-010 rd_ack  output  1  shall be a one-cycle pulse meaning rd_data is valid.
REQ-011 fifo_we / fifo_re  output  1 each  shall be the FIFO write/read strobes.
REQ-012 fifo_din  output  DATA_WIDTH  shall be the registered FIFO write data.
REQ-013 fifo_dout  input  DATA_WIDTH  shall be the FIFO read data.
REQ-014 fifo_busy, fifo_empty, fifo_full  input  1 each  shall be the FIFO status flags.
REQ-015 arb_error  output  1  shall be the sticky busy-timeout flag.

Function
REQ-016 FSM states shall be IDLE, ISSUE, WAIT, ACK; exactly one state active.
REQ-017 In IDLE, a write shall be eligible iff wr_req=1, fifo_full=0, fifo_busy=0; a read iff rd_req=1, fifo_empty=0, fifo_busy=0.
REQ-018 With one eligible requester, it shall be granted; with both, the round-robin pointer shall decide, and the pointer shall then point to the other requester.
REQ-019 With no eligible requester, the FSM shall stay in IDLE; ineligible requests stay pending and are not dropped.
REQ-020 On grant, fifo_din shall load wr_data (write), and the FSM shall enter ISSUE.
REQ-021 ISSUE shall last exactly 1 cycle, asserting fifo_we (write) or fifo_re (read), never both.
REQ-022 WAIT shall last at least 1 cycle and exit when fifo_busy=0 is sampled; on read exit, rd_data shall load fifo_dout.
REQ-023 ACK shall last exactly 1 cycle, pulsing wr_ack or rd_ack, then return to IDLE.
REQ-024 Minimum latency, req sampled in IDLE (cycle 0) to ack, shall be 3 cycles; no back-to-back grants without an IDLE cycle.
REQ-025 A WAIT counter shall count to BUSY_TIMEOUT; on reaching it, arb_error shall set, and the FSM shall go to ACK anyway.
REQ-026 A requester dropping req mid-transaction shall not abort it; the ack is still issued.
REQ-027 fifo_we, fifo_re, wr_ack and rd_ack shall never be asserted in the same cycle as each other.

Reset
REQ-028 With reset=0: state IDLE, round-robin pointer favours write, and all outputs including rd_data, fifo_din and arb_error are 0.
REQ-029 Reset asserted mid-transaction shall abort it with no ack issued; after release, the first IDLE cycle re-arbitrates.
REQ-030 arb_error shall clear only by reset.

Configuration
REQ-031 Macro FIFOARB_FIXED_PRIO_EN defined: eligible write shall always beat eligible read, and the pointer is unused.
REQ-032 Macro undefined: round-robin per REQ-018.

Verification
REQ-033 Write only: wr_req=1, wr_data=8'hA5, busy low -> fifo_we at cycle 1, fifo_din=8'hA5, wr_ack at cycle 3.
REQ-034 Simultaneous: wr_req=rd_req=1 held, FIFO non-empty/non-full -> grants alternate W,R,W,R from reset (fixed W,W,W with FIFOARB_FIXED_PRIO_EN).
REQ-035 Blocking: fifo_full=1 with wr_req and rd_req -> read granted, write pending; fifo_full drops -> write granted next IDLE.
REQ-036 Read: fifo_empty=0, fifo_dout=8'h3C, busy high 4 cycles after fifo_re -> rd_ack 1 cycle after busy low, rd_data=8'h3C.
REQ-037 Timeout: BUSY_TIMEOUT=4, fifo_busy stuck 1 after ISSUE -> arb_error=1 after 4 WAIT cycles, ack pulses, arb_error stays until reset.
REQ-038 Reset in WAIT: reset=0 -> all outputs 0 immediately, no ack; release -> pending request regranted.
